// File: rtl/dff_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_arb_pkg
// Brief    : Shared types and sizing helpers for the dff_write_arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package dff_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    // Burst counter must be able to hold BURST_MAX itself.
    function automatic int cnt_width(input int burst_max);
        return (burst_max < 1) ? 1 : $clog2(burst_max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : dff_reg_bank
// Brief    : WIDTH-bit D register with write enable and complementary outputs.
// Revision : 1.0 - initial release
// ============================================================================
module dff_reg_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_n
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q   = r_q;
    assign o_q_n = ~r_q;

endmodule
`default_nettype wire

// File: rtl/dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_write_arbiter
// Brief    : Round-robin / burst-lock arbiter feeding a shared D register.
// Revision : 1.0 - initial release
// ============================================================================
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               BURST_MAX   = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             input_req0,
    input  logic             input_lock0,
    input  logic [WIDTH-1:0] input_data0,
    input  logic             input_req1,
    input  logic             input_lock1,
    input  logic [WIDTH-1:0] input_data1,
    output logic             output_ack0,
    output logic             output_ack1,
    output logic [WIDTH-1:0] output_q,
    output logic [WIDTH-1:0] output_q_n,
    output logic             output_owner,
    output logic             output_locked
);

    localparam int                c_cnt_w     = cnt_width(BURST_MAX);
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(BURST_MAX);
    localparam bit                c_lock_en   = (BURST_MAX > 1);

    arb_state_t         r_state;
    req_id_t            r_rr;
    req_id_t            r_owner;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_ack0;
    logic               w_ack1;
    logic               w_we;
    req_id_t            w_wid;
    logic               w_wlock;
    logic [WIDTH-1:0]   w_wdata;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    // Acks depend only on registered state and current req/lock.
    always_comb begin
        w_ack0 = 1'b0;
        w_ack1 = 1'b0;
        case (r_state)
            ST_LOCK0: w_ack0 = input_req0;
            ST_LOCK1: w_ack1 = input_req1;
            default: begin
                w_ack0 = input_req0 && (!input_req1 || (r_rr == 1'b0));
                w_ack1 = input_req1 && (!input_req0 || (r_rr == 1'b1));
            end
        endcase
    end

    assign w_we      = w_ack0 | w_ack1;
    assign w_wid     = w_ack1;
    assign w_wlock   = w_ack1 ? input_lock1 : input_lock0;
    assign w_wdata   = w_ack1 ? input_data1 : input_data0;
    assign w_cnt_nxt = r_cnt + c_cnt_w'(1);

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            r_state <= ST_IDLE;
            r_rr    <= 1'b0;
            r_cnt   <= '0;
            r_owner <= 1'b0;
        end else begin
            if (w_we) begin
                r_owner <= w_wid;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_we) begin
                        r_rr <= ~w_wid;
                        if (w_wlock && c_lock_en) begin
                            r_state <= w_wid ? ST_LOCK1 : ST_LOCK0;
                            r_cnt   <= c_cnt_w'(1);
                        end
                    end
                end
                ST_LOCK0: begin
                    // Burst cycles count even when the owner is not requesting.
                    r_cnt <= w_cnt_nxt;
                    if (!input_lock0 || (w_cnt_nxt == c_burst_max)) begin
                        r_state <= ST_IDLE;
                        r_rr    <= 1'b1;
                    end
                end
                ST_LOCK1: begin
                    r_cnt <= w_cnt_nxt;
                    if (!input_lock1 || (w_cnt_nxt == c_burst_max)) begin
                        r_state <= ST_IDLE;
                        r_rr    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    dff_reg_bank #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_reg_bank (
        .clk   (input_clock1_1),
        .rst   (input_reset1_2),
        .i_we  (w_we),
        .i_d   (w_wdata),
        .o_q   (output_q),
        .o_q_n (output_q_n)
    );

    assign output_ack0   = w_ack0;
    assign output_ack1   = w_ack1;
    assign output_owner  = r_owner;
    assign output_locked = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_write_arbiter
// Brief    : Directed self-checking bench for dff_write_arbiter (8-bit, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_write_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, lock0, req1, lock1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, owner, locked;
    logic [7:0] q, q_n;

    int n_tests = 0;
    int n_fail  = 0;

    dff_write_arbiter #(
        .WIDTH       (8),
        .BURST_MAX   (4),
        .RESET_VALUE (8'h00)
    ) dut (
        .input_clock1_1 (clk),
        .input_reset1_2 (rst),
        .input_req0     (req0),
        .input_lock0    (lock0),
        .input_data0    (data0),
        .input_req1     (req1),
        .input_lock1    (lock1),
        .input_data1    (data1),
        .output_ack0    (ack0),
        .output_ack1    (ack1),
        .output_q       (q),
        .output_q_n     (q_n),
        .output_owner   (owner),
        .output_locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic l0, input logic [7:0] d0,
                         input logic r1, input logic l1, input logic [7:0] d1);
        req0  = r0;
        lock0 = l0;
        data0 = d0;
        req1  = r1;
        lock1 = l1;
        data1 = d1;
    endtask

    // Check combinational acks and lock flag, then advance one clock edge.
    task automatic step(input string tag, input logic a0, input logic a1, input logic lk);
        #1;
        chk({tag, ".ack0"},   {7'd0, ack0},   {7'd0, a0});
        chk({tag, ".ack1"},   {7'd0, ack1},   {7'd0, a1});
        chk({tag, ".locked"}, {7'd0, locked}, {7'd0, lk});
        @(posedge clk);
        #1;
    endtask

    task automatic regs(input string tag, input logic [7:0] eq, input logic eo);
        chk({tag, ".q"},     q,               eq);
        chk({tag, ".q_n"},   q_n,             ~eq);
        chk({tag, ".owner"}, {7'd0, owner},   {7'd0, eo});
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 0, 8'hAA, 1, 0, 8'hBB);
        @(posedge clk);
        #1;
        chk("rst1.q", q, 8'h00);
        @(posedge clk);
        #1;
        regs("rst2", 8'h00, 1'b0);
        chk("rst2.locked", {7'd0, locked}, 8'h00);

        // Release reset with both still requesting: first tie goes to 0.
        rst = 1'b0;
        step("tie0", 1, 0, 0);
        regs("tie0", 8'hAA, 1'b0);

        drive(1, 0, 8'hA5, 0, 0, 8'h00);
        step("single", 1, 0, 0);
        regs("single", 8'hA5, 1'b0);

        // Lone requester 1 write returns the rr pointer to 0.
        drive(0, 0, 8'h00, 1, 0, 8'h33);
        step("lone1", 0, 1, 0);
        regs("lone1", 8'h33, 1'b1);

        drive(1, 0, 8'h11, 1, 0, 8'h22);
        step("rr1", 1, 0, 0);
        regs("rr1", 8'h11, 1'b0);
        step("rr2", 0, 1, 0);
        regs("rr2", 8'h22, 1'b1);
        step("rr3", 1, 0, 0);
        regs("rr3", 8'h11, 1'b0);
        step("rr4", 0, 1, 0);
        regs("rr4", 8'h22, 1'b1);

        drive(0, 0, 8'h99, 0, 0, 8'h98);
        step("idle", 0, 0, 0);
        regs("idle", 8'h22, 1'b1);

        // Burst cap: four locked writes, then forced release to requester 1.
        drive(1, 1, 8'h41, 1, 0, 8'h50);
        step("burst1", 1, 0, 0);
        regs("burst1", 8'h41, 1'b0);
        data0 = 8'h42;
        step("burst2", 1, 0, 1);
        regs("burst2", 8'h42, 1'b0);
        data0 = 8'h43;
        step("burst3", 1, 0, 1);
        regs("burst3", 8'h43, 1'b0);
        data0 = 8'h44;
        step("burst4", 1, 0, 1);
        regs("burst4", 8'h44, 1'b0);
        data0 = 8'h45;
        step("burst5", 0, 1, 0);
        regs("burst5", 8'h50, 1'b1);
        data0 = 8'h46;
        step("burst6", 1, 0, 0);
        regs("burst6", 8'h46, 1'b0);
        // Owner idle and unlocking releases the lock with no write.
        drive(0, 0, 8'h47, 0, 0, 8'h51);
        step("burst7", 0, 0, 1);
        regs("burst7", 8'h46, 1'b0);
        chk("burst7.unlocked", {7'd0, locked}, 8'h00);

        drive(0, 0, 8'h00, 1, 0, 8'h60);
        step("lone1b", 0, 1, 0);
        regs("lone1b", 8'h60, 1'b1);

        // Early unlock on the second cycle.
        drive(1, 1, 8'h71, 1, 0, 8'h73);
        step("early1", 1, 0, 0);
        regs("early1", 8'h71, 1'b0);
        drive(1, 0, 8'h72, 1, 0, 8'h73);
        step("early2", 1, 0, 1);
        regs("early2", 8'h72, 1'b0);
        step("early3", 0, 1, 0);
        regs("early3", 8'h73, 1'b1);

        // Enter LOCK1, reach cnt=2, then reset mid-burst.
        drive(0, 0, 8'h00, 1, 1, 8'h81);
        step("lock1a", 0, 1, 0);
        regs("lock1a", 8'h81, 1'b1);
        data1 = 8'h82;
        step("lock1b", 0, 1, 1);
        regs("lock1b", 8'h82, 1'b1);
        rst = 1'b1;
        drive(1, 0, 8'h90, 1, 1, 8'h7E);
        @(posedge clk);
        #1;
        regs("midrst", 8'h00, 1'b0);
        chk("midrst.locked", {7'd0, locked}, 8'h00);
        rst = 1'b0;
        drive(1, 0, 8'h91, 1, 0, 8'h92);
        step("postrst", 1, 0, 0);
        regs("postrst", 8'h91, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
